// File: rtl/memory_unit_if.sv
// Shared-bus and status signals of memory_unit.
// The slave modport is used by memory_unit and the master modport by whatever drives it.
interface memory_unit_if;
    logic [14:0] ctrl;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [3:0]  mar_q;
    logic        wr_ack;
    logic [7:0]  wr_count;
    logic        err;

    modport master (
        output ctrl, bus_in,
        input  bus_out, bus_oe, mar_q, wr_ack, wr_count, err
    );

    modport slave (
        input  ctrl, bus_in,
        output bus_out, bus_oe, mar_q, wr_ack, wr_count, err
    );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: 16x8 RAM behind a MAR/MDR pair that are loaded from the shared bus.
// It also reports write ack/count. Defining MEM_CONFLICT_DET_EN enables the sticky bus-conflict flag.
module memory_unit (
    input  logic          clk,
    input  logic          resetn,
    memory_unit_if.slave  mem
);

    logic [3:0] mar_q, mar_d;
    logic [7:0] mdr_q, mdr_d;
    logic [7:0] ram_q [16];
    logic       wr_ack_q, wr_ack_d;
    logic [7:0] wr_count_q, wr_count_d;
    logic       we;
    logic       oe;

    // Storage only looks at ctrl[11:8]; the other bits feed conflict detection.
    logic unused_ctrl;
    assign unused_ctrl = ^{mem.ctrl[14:12], mem.ctrl[7:0]};

    always_comb begin
        we         = ~mem.ctrl[8];
        mar_d      = mem.ctrl[11] ? mar_q : mem.bus_in[3:0];
        mdr_d      = mem.ctrl[10] ? mdr_q : mem.bus_in;
        wr_ack_d   = we;
        wr_count_d = (we && (wr_count_q != 8'hFF)) ? wr_count_q + 8'd1 : wr_count_q;
    end

    // The write uses the pre-edge MAR/MDR, so a same-edge reload only affects the next access.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mar_q      <= '0;
            mdr_q      <= '0;
            wr_ack_q   <= 1'b0;
            wr_count_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                ram_q[i] <= '0;
            end
        end else begin
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            wr_ack_q   <= wr_ack_d;
            wr_count_q <= wr_count_d;
            if (we) begin
                ram_q[mar_q] <= mdr_q;
            end
        end
    end

    assign oe           = ~mem.ctrl[9];
    assign mem.bus_oe   = oe;
    assign mem.bus_out  = oe ? ram_q[mar_q] : '0;
    assign mem.mar_q    = mar_q;
    assign mem.wr_ack   = wr_ack_q;
    assign mem.wr_count = wr_count_q;

`ifdef MEM_CONFLICT_DET_EN
    logic err_q, err_d;
    logic conflict;

    // Another source is also enabled onto the bus, or a bus load overlaps the read.
    always_comb begin
        conflict = ~mem.ctrl[9] & (mem.ctrl[13] | ~mem.ctrl[6] | mem.ctrl[4] |
                                   mem.ctrl[2] | ~mem.ctrl[11] | ~mem.ctrl[10]);
        err_d    = err_q | conflict;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem.err = err_q;
`else
    assign mem.err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit with a behavioural reference model of RAM, MAR, MDR, counters and error flag.
module tb_memory_unit;

    localparam logic [14:0] IDLE = 15'h0FE3;
    localparam logic [14:0] N_LMA = 15'h0800;
    localparam logic [14:0] N_LMD = 15'h0400;
    localparam logic [14:0] N_CE  = 15'h0200;
    localparam logic [14:0] N_LR  = 15'h0100;
    localparam logic [14:0] B_EA  = 15'h0010;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    memory_unit_if bus_if ();

    memory_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .mem    (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_ram [16];
    logic [3:0] m_mar;
    logic [7:0] m_mdr;
    int         m_cnt;
    logic       m_ack;
    logic       m_err;

    function automatic logic [7:0] exp_bus_out();
        return bus_if.ctrl[9] ? 8'h00 : m_ram[m_mar];
    endfunction

    // Apply one cycle of stimulus; the model advances with the pre-edge values.
    task automatic step(input logic [14:0] c, input logic [7:0] b, input logic rn);
        logic wr;
        logic conf;
        bus_if.ctrl   = c;
        bus_if.bus_in = b;
        resetn        = rn;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
            m_mar = 4'h0; m_mdr = 8'h00; m_cnt = 0; m_ack = 1'b0; m_err = 1'b0;
        end else begin
            wr   = !c[8];
            conf = !c[9] && (c[13] || !c[6] || c[4] || c[2] || !c[11] || !c[10]);
            if (wr) m_ram[m_mar] = m_mdr;
            if (!c[11]) m_mar = b[3:0];
            if (!c[10]) m_mdr = b;
            m_ack = wr;
            if (wr && m_cnt < 255) m_cnt = m_cnt + 1;
`ifdef MEM_CONFLICT_DET_EN
            if (conf) m_err = 1'b1;
`else
            if (conf) m_err = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        step(IDLE, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(IDLE, 8'h00, 1'b1);
        vectors++; if (bus_if.mar_q !== 4'h0) begin miscompares++; $display("FAIL reset_mar got=%h exp=0", bus_if.mar_q); end
        vectors++; if (bus_if.bus_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got=%b exp=0", bus_if.bus_oe); end
        vectors++; if (bus_if.bus_out !== 8'h00) begin miscompares++; $display("FAIL reset_out got=%h exp=00", bus_if.bus_out); end
        vectors++; if (bus_if.wr_count !== 8'h00) begin miscompares++; $display("FAIL reset_cnt got=%h exp=00", bus_if.wr_count); end
        vectors++; if (bus_if.wr_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", bus_if.wr_ack); end
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus_if.err); end
    endtask

    task automatic test_write_read();
        step(IDLE & ~N_LMA, 8'h35, 1'b1);
        vectors++; if (bus_if.mar_q !== 4'h5) begin miscompares++; $display("FAIL mar_load got=%h exp=5", bus_if.mar_q); end
        step(IDLE & ~N_LMD, 8'hA7, 1'b1);
        step(IDLE & ~N_LR, 8'h00, 1'b1);
        vectors++; if (bus_if.wr_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack_pulse got=%b exp=1", bus_if.wr_ack); end
        vectors++; if (bus_if.wr_count !== 8'd1) begin miscompares++; $display("FAIL wr_count_one got=%h exp=01", bus_if.wr_count); end
        step(IDLE, 8'h00, 1'b1);
        vectors++; if (bus_if.wr_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_drop got=%b exp=0", bus_if.wr_ack); end
        step(IDLE & ~N_LMA, 8'h05, 1'b1);
        bus_if.ctrl = IDLE & ~N_CE; #1;
        vectors++; if (bus_if.bus_oe !== 1'b1) begin miscompares++; $display("FAIL read_oe got=%b exp=1", bus_if.bus_oe); end
        vectors++; if (bus_if.bus_out !== 8'hA7) begin miscompares++; $display("FAIL read_a7 got=%h exp=A7", bus_if.bus_out); end
        step(IDLE & ~N_LMD, 8'h3C, 1'b1);
        bus_if.ctrl = IDLE & ~N_CE & ~N_LR; #1;
        vectors++; if (bus_if.bus_out !== 8'hA7) begin miscompares++; $display("FAIL rw_pre got=%h exp=A7", bus_if.bus_out); end
        step(IDLE & ~N_CE & ~N_LR, 8'h00, 1'b1);
        vectors++; if (bus_if.bus_out !== 8'h3C) begin miscompares++; $display("FAIL rw_post got=%h exp=3C", bus_if.bus_out); end
        vectors++; if (bus_if.bus_out !== exp_bus_out()) begin miscompares++; $display("FAIL rw_model got=%h exp=%h", bus_if.bus_out, exp_bus_out()); end
        step(IDLE, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [14:0] c;
        logic        rn;
        for (int n = 0; n < 200; n++) begin
            c  = 15'($urandom);
            if ($urandom_range(0, 1) == 0) c[8] = 1'b1;
            rn = ($urandom_range(0, 31) != 0);
            step(c, 8'($urandom), rn);
            vectors++; if (bus_if.mar_q !== m_mar) begin miscompares++; $display("FAIL rnd_mar n=%0d got=%h exp=%h", n, bus_if.mar_q, m_mar); end
            vectors++; if (bus_if.bus_oe !== ~c[9]) begin miscompares++; $display("FAIL rnd_oe n=%0d got=%b exp=%b", n, bus_if.bus_oe, ~c[9]); end
            vectors++; if (bus_if.bus_out !== exp_bus_out()) begin miscompares++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, bus_if.bus_out, exp_bus_out()); end
            vectors++; if (bus_if.wr_ack !== m_ack) begin miscompares++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, bus_if.wr_ack, m_ack); end
            vectors++; if (bus_if.wr_count !== 8'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt n=%0d got=%h exp=%h", n, bus_if.wr_count, 8'(m_cnt)); end
            vectors++; if (bus_if.err !== m_err) begin miscompares++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus_if.err, m_err); end
        end
        // Read every entry back through the bus.
        for (int a = 0; a < 16; a++) begin
            step(IDLE & ~N_LMA, 8'(a), 1'b1);
            bus_if.ctrl = IDLE & ~N_CE; #1;
            vectors++; if (bus_if.bus_out !== m_ram[a]) begin miscompares++; $display("FAIL rnd_dump a=%0d got=%h exp=%h", a, bus_if.bus_out, m_ram[a]); end
        end
        step(IDLE, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            step(IDLE & ~N_LR, 8'h00, 1'b1);
            vectors++; if (bus_if.wr_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack n=%0d got=%b exp=1", n, bus_if.wr_ack); end
            vectors++; if (bus_if.wr_count !== ((n < 255) ? 8'(n + 1) : 8'hFF)) begin miscompares++; $display("FAIL b2b_cnt n=%0d got=%h", n, bus_if.wr_count); end
        end
        step(IDLE, 8'h00, 1'b1);
        vectors++; if (bus_if.wr_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_end got=%b exp=0", bus_if.wr_ack); end
        vectors++; if (bus_if.wr_count !== 8'hFF) begin miscompares++; $display("FAIL b2b_sat got=%h exp=FF", bus_if.wr_count); end
    endtask

    task automatic test_conflict();
        logic exp_err;
`ifdef MEM_CONFLICT_DET_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        step(IDLE & ~N_CE | B_EA, 8'h00, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(IDLE, 8'h00, 1'b1);
            vectors++; if (bus_if.err !== exp_err) begin miscompares++; $display("FAIL conflict_err n=%0d got=%b exp=%b", n, bus_if.err, exp_err); end
        end
        step(IDLE, 8'h00, 1'b0);
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL conflict_clear got=%b exp=0", bus_if.err); end
    endtask

    task automatic test_reset_discard();
        step(IDLE & ~N_LMA, 8'h09, 1'b1);
        step(IDLE & ~N_LMD, 8'hFF, 1'b1);
        step(IDLE & ~N_LR, 8'h00, 1'b0);
        vectors++; if (bus_if.wr_count !== 8'h00) begin miscompares++; $display("FAIL rstw_cnt got=%h exp=00", bus_if.wr_count); end
        vectors++; if (bus_if.wr_ack !== 1'b0) begin miscompares++; $display("FAIL rstw_ack got=%b exp=0", bus_if.wr_ack); end
        step(IDLE & ~N_LMA, 8'h09, 1'b1);
        bus_if.ctrl = IDLE & ~N_CE; #1;
        vectors++; if (bus_if.bus_out !== 8'h00) begin miscompares++; $display("FAIL rstw_ram got=%h exp=00", bus_if.bus_out); end
        step(IDLE, 8'h00, 1'b1);
    endtask

    initial begin
        bus_if.ctrl   = IDLE;
        bus_if.bus_in = 8'h00;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_mar = '0; m_mdr = '0; m_cnt = 0; m_ack = 1'b0; m_err = 1'b0;
        test_reset();
        test_write_read();
        test_random();
        test_back_to_back();
        test_conflict();
        test_reset_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
